// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal transmit FIFO and a run-time frame format
// (divisor, data length, parity, stop bits) latched at the start of every frame.
module uart_tx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int DIV_W        = 16
) (
    input  logic                               clk,
    input  logic                               tx_reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [PAYLOAD_BITS-1:0]            in_data,
    input  logic [DIV_W-1:0]                   cfg_baud_div,
    input  logic [$clog2(PAYLOAD_BITS+1)-1:0]  cfg_data_len,
    input  logic [1:0]                         cfg_parity,
    input  logic                               cfg_stop2,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               tx_busy,
    output logic                               tx_done,
    output logic                               tx_serial
);

    localparam int LEN_W = $clog2(PAYLOAD_BITS + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;

    state_t                  r_state;
    logic [PAYLOAD_BITS-1:0] r_buf;
    logic [DIV_W-1:0]        r_div;
    logic [LEN_W-1:0]        r_len;
    logic                    r_par_en;
    logic                    r_par_bit;
    logic                    r_stop2;
    logic [DIV_W-1:0]        r_div_cnt;
    logic [LEN_W-1:0]        r_bit_idx;
    logic                    r_stop_idx;
    logic                    r_tx_serial;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_done;
    logic                    w_bit_end;
    logic                    w_serial_next;
    logic                    w_head_par;
    logic [PAYLOAD_BITS-1:0] w_head;
    logic [PAYLOAD_BITS-1:0] w_mask;
    logic [PAYLOAD_BITS-1:0] w_shifted;
    logic [DIV_W-1:0]        w_div_eff;
    logic [LEN_W-1:0]        w_len_eff;
    state_t                  w_next_state;
    logic [DIV_W-1:0]        w_next_div_cnt;
    logic [LEN_W-1:0]        w_next_bit_idx;
    logic                    w_next_stop_idx;

    assign in_ready   = (r_count != CNT_W'(FIFO_DEPTH));
    assign fifo_count = r_count;
    assign w_push     = in_valid && in_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign tx_busy    = (r_state != S_IDLE);
    assign tx_done    = w_done && !tx_reset;
    assign tx_serial  = r_tx_serial;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Clamp the requested format and precompute parity over only the LEN used bits.
    always_comb begin
        w_div_eff = (cfg_baud_div < DIV_W'(2)) ? DIV_W'(2) : cfg_baud_div;
        if (cfg_data_len < LEN_W'(5)) begin
            w_len_eff = LEN_W'(5);
        end else if (cfg_data_len > LEN_W'(PAYLOAD_BITS)) begin
            w_len_eff = LEN_W'(PAYLOAD_BITS);
        end else begin
            w_len_eff = cfg_data_len;
        end
        w_mask     = ~({PAYLOAD_BITS{1'b1}} << w_len_eff);
        w_head_par = ^(w_head & w_mask);
    end

    always_ff @(posedge clk) begin
        if (tx_reset) begin
            r_buf     <= '0;
            r_div     <= DIV_W'(2);
            r_len     <= LEN_W'(PAYLOAD_BITS);
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
        end else if (w_pop) begin
            r_buf     <= w_head;
            r_div     <= w_div_eff;
            r_len     <= w_len_eff;
            r_par_en  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            r_par_bit <= w_head_par ^ (cfg_parity == 2'b10);
            r_stop2   <= cfg_stop2;
        end
    end

    assign w_bit_end = (r_div_cnt == r_div - DIV_W'(1));

    always_comb begin
        w_next_state    = r_state;
        w_next_div_cnt  = r_div_cnt + DIV_W'(1);
        w_next_bit_idx  = r_bit_idx;
        w_next_stop_idx = r_stop_idx;
        w_pop           = 1'b0;
        w_done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_div_cnt = '0;
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_next_state   = S_DATA;
                    w_next_div_cnt = '0;
                    w_next_bit_idx = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_next_div_cnt = '0;
                    if (r_bit_idx == r_len - LEN_W'(1)) begin
                        w_next_state    = r_par_en ? S_PARITY : S_STOP;
                        w_next_stop_idx = 1'b0;
                    end else begin
                        w_next_bit_idx = r_bit_idx + LEN_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_next_state    = S_STOP;
                    w_next_div_cnt  = '0;
                    w_next_stop_idx = 1'b0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_next_div_cnt = '0;
                    if (r_stop_idx == r_stop2) begin
                        w_done       = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_stop_idx = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state   = S_IDLE;
                w_next_div_cnt = '0;
            end
        endcase
    end

    // The line is registered from the next state so it changes on the same edge as the FSM.
    always_comb begin
        w_shifted     = r_buf >> w_next_bit_idx;
        w_serial_next = 1'b1;
        case (w_next_state)
            S_START:  w_serial_next = 1'b0;
            S_DATA:   w_serial_next = w_shifted[0];
            S_PARITY: w_serial_next = r_par_bit;
            default:  w_serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_reset) begin
            r_state     <= S_IDLE;
            r_div_cnt   <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_tx_serial <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_div_cnt   <= w_next_div_cnt;
            r_bit_idx   <= w_next_bit_idx;
            r_stop_idx  <= w_next_stop_idx;
            r_tx_serial <= w_serial_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: frame shapes, parity, clamping,
// FIFO back-pressure, mid-frame config change and mid-frame reset.
module tb_uart_tx_fifo;

    logic        clk;
    logic        tx_reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [15:0] cfg_baud_div;
    logic [3:0]  cfg_data_len;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic [3:0]  fifo_count;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_serial;

    int checkCount = 0;
    int passCount  = 0;

    uart_tx_fifo #(.PAYLOAD_BITS(8), .FIFO_DEPTH(8), .DIV_W(16)) dut (
        .clk          (clk),
        .tx_reset     (tx_reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .cfg_baud_div (cfg_baud_div),
        .cfg_data_len (cfg_data_len),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .fifo_count   (fifo_count),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_serial    (tx_serial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] word);
        in_valid = 1'b1;
        in_data  = word;
        step();
        in_valid = 1'b0;
    endtask

    task automatic setFormat(input int div, input int len, input int parMode, input int stop2);
        cfg_baud_div = 16'(div);
        cfg_data_len = 4'(len);
        cfg_parity   = 2'(parMode);
        cfg_stop2    = stop2[0];
    endtask

    // Waits for the frame to start, then compares every cycle against the expected bit stream.
    task automatic checkFrame(input string tag, input logic [7:0] word, input int div, input int len,
                              input int parMode, input int nStop, output int waited);
        bit e[0:15];
        bit par;
        int nb;
        int total;
        int bitErr;
        e[0] = 1'b0;
        nb   = 1;
        par  = 1'b0;
        for (int i = 0; i < len; i++) begin
            e[nb] = word[i];
            par   = par ^ word[i];
            nb++;
        end
        if (parMode != 0) begin
            e[nb] = (parMode == 2) ? ~par : par;
            nb++;
        end
        for (int i = 0; i < nStop; i++) begin
            e[nb] = 1'b1;
            nb++;
        end
        total  = nb * div;
        waited = 0;
        while (!tx_busy && waited < 500) begin
            step();
            waited++;
        end
        if (!tx_busy) begin
            checkOutput({tag, "_start"}, 32'd0, 32'd1);
            return;
        end
        bitErr = 0;
        for (int c = 0; c < total; c++) begin
            if (tx_serial !== e[c / div] || tx_busy !== 1'b1 || tx_done !== (c == total - 1)) begin
                bitErr++;
            end
            step();
        end
        checkOutput({tag, "_bits"}, 32'(bitErr), 32'd0);
        checkOutput({tag, "_idle"}, {29'd0, tx_busy, tx_serial, tx_done}, 32'b010);
    endtask

    initial begin
        logic [7:0] ws [10];
        int waited;
        int gapErr;
        int stallAt;
        int stallCnt;
        int riseCnt;
        int activity;

        tx_reset = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        setFormat(4, 8, 0, 0);
        step();
        step();
        checkOutput("rst_serial", {31'd0, tx_serial}, 32'd1);
        checkOutput("rst_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("rst_done", {31'd0, tx_done}, 32'd0);
        checkOutput("rst_count", {28'd0, fifo_count}, 32'd0);
        checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
        tx_reset = 1'b0;
        step();

        $display("[TB] 8N1 / 8E2 / 8O2 frames");
        setFormat(4, 8, 0, 0);
        applyStimulus(8'hA5);
        checkOutput("t1_cnt1", {28'd0, fifo_count}, 32'd1);
        checkFrame("t1", 8'hA5, 4, 8, 0, 1, waited);
        checkOutput("t1_cnt0", {28'd0, fifo_count}, 32'd0);
        setFormat(4, 8, 1, 1);
        applyStimulus(8'hA5);
        checkFrame("t2_even", 8'hA5, 4, 8, 1, 2, waited);
        setFormat(4, 8, 2, 1);
        applyStimulus(8'hA5);
        checkFrame("t3_odd", 8'hA5, 4, 8, 2, 2, waited);

        $display("[TB] short length and clamping");
        setFormat(3, 5, 1, 0);
        applyStimulus(8'hFF);
        checkFrame("t4_len5", 8'hFF, 3, 5, 1, 1, waited);
        setFormat(3, 3, 1, 0);
        applyStimulus(8'hFF);
        checkFrame("t5_len3", 8'hFF, 3, 5, 1, 1, waited);
        setFormat(0, 8, 0, 0);
        applyStimulus(8'h3C);
        checkFrame("t7_div0", 8'h3C, 2, 8, 0, 1, waited);

        $display("[TB] FIFO fill and back-pressure");
        for (int k = 0; k < 10; k++) begin
            ws[k] = 8'(8'h11 * k + 8'h05);
        end
        setFormat(3, 8, 0, 0);
        gapErr   = 0;
        stallAt  = -1;
        stallCnt = -1;
        riseCnt  = -1;
        in_valid = 1'b1;
        in_data  = ws[0];
        step();
        fork
            begin
                int w;
                for (int k = 0; k < 10; k++) begin
                    checkFrame($sformatf("t6w%0d", k), ws[k], 3, 8, 0, 1, w);
                    if (w != 1) gapErr++;
                end
            end
            begin
                for (int k = 1; k < 10; k++) begin
                    int guard;
                    guard   = 0;
                    in_data = ws[k];
                    while (!in_ready && guard < 200) begin
                        if (guard == 0) begin
                            stallAt  = k;
                            stallCnt = int'(fifo_count);
                        end
                        step();
                        guard++;
                    end
                    if (guard > 0) riseCnt = int'(fifo_count);
                    step();
                end
                in_valid = 1'b0;
            end
        join
        checkOutput("t6_gap", 32'(gapErr), 32'd0);
        checkOutput("t6_stall_at", 32'(stallAt), 32'd9);
        checkOutput("t6_stall_cnt", 32'(stallCnt), 32'd8);
        checkOutput("t6_rise_cnt", 32'(riseCnt), 32'd7);

        $display("[TB] divisor change mid-frame");
        setFormat(4, 8, 0, 0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();
        in_data  = 8'hC3;
        step();
        in_valid = 1'b0;
        fork
            begin
                int w;
                checkFrame("t8_div4", 8'h5A, 4, 8, 0, 1, w);
                checkFrame("t8_div8", 8'hC3, 8, 8, 0, 1, w);
            end
            begin
                repeat (10) step();
                cfg_baud_div = 16'd8;
            end
        join

        $display("[TB] reset during DATA");
        setFormat(4, 8, 0, 0);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 8'hF0 + 8'(k);
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        checkOutput("t9_pre_busy", {31'd0, tx_busy}, 32'd1);
        checkOutput("t9_pre_cnt", {28'd0, fifo_count}, 32'd3);
        tx_reset = 1'b1;
        step();
        tx_reset = 1'b0;
        checkOutput("t9_serial", {31'd0, tx_serial}, 32'd1);
        checkOutput("t9_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("t9_count", {28'd0, fifo_count}, 32'd0);
        checkOutput("t9_done", {31'd0, tx_done}, 32'd0);
        activity = 0;
        for (int c = 0; c < 100; c++) begin
            if (tx_busy || !tx_serial || tx_done) activity++;
            step();
        end
        checkOutput("t9_quiet", 32'(activity), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
